panel_lamp_driver: RTL and testbench

- Front-panel indicator output path; the counterpart to the debounced switch inputs.
- Holds a double-buffered lamp image for a multiplexed ROWS x COLS LED matrix.
- Scans one column at a time, with an anti-ghosting blank interval between columns.
- Accepts per-column writes over a valid/ready handshake; commits them atomically at a frame boundary.

---
 rtl/panel_pkg.sv | 22 ++
 rtl/panel_scan_timer.sv | 95 +++++++++
 rtl/panel_lamp_driver.sv | 133 +++++++++++++
 tb/tb_panel_lamp_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared constants and types for the front-panel lamp matrix driver.
package panel_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  // Column-index width; never narrower than one bit so a single-column panel still elaborates.
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = col_w(COLS_DEF);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Active-low column enables: all ones means every column is off.
  localparam logic [31:0] COL_ALL_OFF = '1;

endpackage

// File: rtl/panel_scan_timer.sv
// Column scan timebase: slot counter, column index, BLANK/ON state and frame_start.
// With LAMP_BLINK_EN it also keeps the blink frame counter and blink phase.
module panel_scan_timer
  import panel_pkg::*;
#(
  parameter int COLS         = COLS_DEF,
  parameter int SCAN_DIV     = 375,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 2048
) (
  input  logic                     hwclk,
  input  logic                     reset_n,
  output logic [col_w(COLS)-1:0]   col_nxt_o,
  output logic                     on_nxt_o,
  output logic                     wrap_o,
`ifdef LAMP_BLINK_EN
  output logic                     blink_phase_o,
`endif
  output logic                     frame_start_o
);

  localparam int CW = col_w(COLS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  scan_state_e   state_q, state_d;
  logic          started_q;
  logic          fs_q;
  logic          slot_end, frame_end;

  always_comb begin
    slot_end  = (cnt_q == SW'(SCAN_DIV - 1));
    frame_end = slot_end && (col_q == CW'(COLS - 1));
    // The release edge itself counts as a frame boundary so the first frame is announced.
    wrap_o    = !started_q || frame_end;
    cnt_d     = cnt_q;
    col_d     = col_q;
    state_d   = state_q;
    if (started_q) begin
      if (slot_end) begin
        cnt_d   = '0;
        col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        state_d = ST_BLANK;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(BLANK_CYCLES - 1)) state_d = ST_ON;
      end
    end
    col_nxt_o = col_d;
    on_nxt_o  = (state_d == ST_ON);
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      col_q     <= '0;
      state_q   <= ST_BLANK;
      started_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      state_q   <= state_d;
      started_q <= 1'b1;
      fs_q      <= wrap_o;
    end
  end

  assign frame_start_o = fs_q;

`ifdef LAMP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q;
  logic          phase_q;

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign blink_phase_o = phase_q;
`endif

endmodule

// File: rtl/panel_lamp_driver.sv
// Double-buffered ROWS x COLS lamp matrix driver with blanked column scan.
// Optional blink mask and blink phase output are enabled by defining LAMP_BLINK_EN.
module panel_lamp_driver
  import panel_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int SCAN_DIV     = 375,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 2048
) (
  input  logic                    hwclk,
  input  logic                    reset_n,
  input  logic                    lamp_wr_valid,
  output logic                    lamp_wr_ready,
  input  logic [col_w(COLS)-1:0]  lamp_wr_col,
  input  logic [ROWS-1:0]         lamp_wr_data,
  input  logic                    lamp_commit,
  output logic                    commit_pending,
`ifdef LAMP_BLINK_EN
  input  logic [ROWS-1:0]         blink_wr_data,
  output logic                    blink_phase,
`endif
  output logic                    frame_start,
  output logic [COLS-1:0]         col_drive_n,
  output logic [ROWS-1:0]         row_drive
);

  localparam int CW = col_w(COLS);

  logic [CW-1:0]   col_nxt;
  logic            on_nxt;
  logic            wrap;
  logic [ROWS-1:0] back_q  [COLS];
  logic [ROWS-1:0] front_q [COLS];
  logic            pending_q, pending_d;
  logic            wr_fire;
  logic [COLS-1:0] col_sel;
  logic [COLS-1:0] col_drive_n_q, col_drive_n_d;
  logic [ROWS-1:0] row_drive_q, row_drive_d;

`ifdef LAMP_BLINK_EN
  logic [ROWS-1:0] bback_q  [COLS];
  logic [ROWS-1:0] bfront_q [COLS];
  logic            phase;
  assign blink_phase = phase;
`endif

  panel_scan_timer #(
    .COLS         (COLS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .hwclk         (hwclk),
    .reset_n       (reset_n),
    .col_nxt_o     (col_nxt),
    .on_nxt_o      (on_nxt),
    .wrap_o        (wrap),
`ifdef LAMP_BLINK_EN
    .blink_phase_o (phase),
`endif
    .frame_start_o (frame_start)
  );

  always_comb begin
    // Out-of-range columns still complete the handshake but touch nothing.
    wr_fire   = lamp_wr_valid && lamp_wr_ready && ({1'b0, lamp_wr_col} < (CW + 1)'(COLS));
    pending_d = pending_q;
    if (wrap && pending_q) pending_d = 1'b0;
    else if (lamp_commit)  pending_d = 1'b1;

    col_sel          = '0;
    col_sel[col_nxt] = 1'b1;
    col_drive_n_d    = COL_ALL_OFF[COLS-1:0];
    row_drive_d      = '0;
    if (on_nxt) begin
      col_drive_n_d = ~col_sel;
`ifdef LAMP_BLINK_EN
      row_drive_d   = front_q[col_nxt] & ~(bfront_q[col_nxt] & {ROWS{phase}});
`else
      row_drive_d   = front_q[col_nxt];
`endif
    end
  end

  // Back buffer is frozen while a commit is pending, so the copy sees a stable image.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < COLS; c++) begin
        back_q[c]  <= '0;
        front_q[c] <= '0;
`ifdef LAMP_BLINK_EN
        bback_q[c]  <= '0;
        bfront_q[c] <= '0;
`endif
      end
      pending_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        back_q[lamp_wr_col] <= lamp_wr_data;
`ifdef LAMP_BLINK_EN
        bback_q[lamp_wr_col] <= blink_wr_data;
`endif
      end
      if (wrap && pending_q) begin
        for (int c = 0; c < COLS; c++) begin
          front_q[c] <= back_q[c];
`ifdef LAMP_BLINK_EN
          bfront_q[c] <= bback_q[c];
`endif
        end
      end
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      col_drive_n_q <= COL_ALL_OFF[COLS-1:0];
      row_drive_q   <= '0;
    end else begin
      col_drive_n_q <= col_drive_n_d;
      row_drive_q   <= row_drive_d;
    end
  end

  assign lamp_wr_ready  = !pending_q;
  assign commit_pending = pending_q;
  assign col_drive_n    = col_drive_n_q;
  assign row_drive      = row_drive_q;

endmodule

// File: tb/tb_panel_lamp_driver.sv
// Randomized bench for panel_lamp_driver with a frame-level behavioural model and directed pins.
module tb_panel_lamp_driver;

  localparam int ROWS         = 8;
  localparam int COLS         = 5;
  localparam int SCAN_DIV     = 20;
  localparam int BLANK        = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = COLS * SCAN_DIV;
  localparam int CW           = $clog2(COLS);

  logic            hwclk = 1'b0;
  logic            reset_n = 1'b0;
  logic            lamp_wr_valid = 1'b0;
  logic            lamp_wr_ready;
  logic [CW-1:0]   lamp_wr_col = '0;
  logic [ROWS-1:0] lamp_wr_data = '0;
  logic            lamp_commit = 1'b0;
  logic            commit_pending;
  logic            frame_start;
  logic [COLS-1:0] col_drive_n;
  logic [ROWS-1:0] row_drive;
`ifdef LAMP_BLINK_EN
  logic [ROWS-1:0] blink_wr_data = '0;
  logic            blink_phase;
`endif

  always #5 hwclk = ~hwclk;

  panel_lamp_driver #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .hwclk          (hwclk),
    .reset_n        (reset_n),
    .lamp_wr_valid  (lamp_wr_valid),
    .lamp_wr_ready  (lamp_wr_ready),
    .lamp_wr_col    (lamp_wr_col),
    .lamp_wr_data   (lamp_wr_data),
    .lamp_commit    (lamp_commit),
    .commit_pending (commit_pending),
`ifdef LAMP_BLINK_EN
    .blink_wr_data  (blink_wr_data),
    .blink_phase    (blink_phase),
`endif
    .frame_start    (frame_start),
    .col_drive_n    (col_drive_n),
    .row_drive      (row_drive)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: m_cyc is the cycle number within the run, 0 = first frame_start cycle.
  logic [ROWS-1:0] m_back  [COLS];
  logic [ROWS-1:0] m_front [COLS];
  logic [ROWS-1:0] m_bback [COLS];
  logic [ROWS-1:0] m_bfront[COLS];
  bit              m_pend, m_run, m_phase;
  int              m_cyc, m_fcnt;
  bit              m_wrap, m_oldp;

  initial begin : model
    forever begin
      @(posedge hwclk or negedge reset_n);
      if (!reset_n) begin
        for (int c = 0; c < COLS; c++) begin
          m_back[c] = '0; m_front[c] = '0; m_bback[c] = '0; m_bfront[c] = '0;
        end
        m_pend = 0; m_run = 0; m_cyc = 0; m_phase = 0; m_fcnt = 0;
      end else begin
        m_wrap = !m_run || ((m_cyc + 1) % FRAME == 0);
        m_oldp = m_pend;
        if (lamp_wr_valid && !m_oldp && int'(lamp_wr_col) < COLS) begin
          m_back[lamp_wr_col] = lamp_wr_data;
`ifdef LAMP_BLINK_EN
          m_bback[lamp_wr_col] = blink_wr_data;
`endif
        end
        if (m_wrap && m_oldp) begin
          for (int c = 0; c < COLS; c++) begin
            m_front[c] = m_back[c];
            m_bfront[c] = m_bback[c];
          end
          m_pend = 0;
        end else if (lamp_commit) begin
          m_pend = 1;
        end
        if (m_run && ((m_cyc + 1) % FRAME == 0)) begin
          if (m_fcnt == BLINK_FRAMES - 1) begin m_fcnt = 0; m_phase = !m_phase; end
          else m_fcnt++;
        end
        if (!m_run) begin m_run = 1; m_cyc = 0; end
        else m_cyc++;
      end
    end
  end

  int fs_hits[$];
  int first_c0 = -1;
  logic [COLS-1:0] e_col, one;
  logic [ROWS-1:0] e_row;
  int slot, col;

  initial begin : compare
    forever begin
      @(negedge hwclk);
      e_col = '1; e_row = '0;
      if (m_run) begin
        slot = m_cyc % SCAN_DIV;
        col  = (m_cyc / SCAN_DIV) % COLS;
        if (slot >= BLANK) begin
          one   = 1;
          e_col = ~(one << col);
          e_row = m_front[col];
`ifdef LAMP_BLINK_EN
          e_row = m_front[col] & ~(m_bfront[col] & {ROWS{m_phase}});
`endif
        end
      end
      check("col_drive_n", 32'(col_drive_n), 32'(e_col));
      check("row_drive", 32'(row_drive), 32'(e_row));
      check("frame_start", 32'(frame_start), 32'(m_run && (m_cyc % FRAME == 0)));
      check("commit_pending", 32'(commit_pending), 32'(m_pend));
      check("lamp_wr_ready", 32'(lamp_wr_ready), 32'(!m_pend));
`ifdef LAMP_BLINK_EN
      check("blink_phase", 32'(blink_phase), 32'(m_phase));
`endif
      if (m_run && frame_start) fs_hits.push_back(m_cyc);
      if (m_run && first_c0 < 0 && !col_drive_n[0]) first_c0 = m_cyc;
    end
  end

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic goto(input int ph);
    int n;
    n = 0;
    step();
    while ((m_cyc % FRAME) != ph && n < 3 * FRAME) begin
      step();
      n++;
    end
    if (n >= 3 * FRAME) begin
      checks++; failures++;
      $display("FAIL goto: frame phase %0d not reached", ph);
    end
  endtask

  task automatic do_write(input int c, input logic [ROWS-1:0] d, input bit commit);
    lamp_wr_valid = 1'b1;
    lamp_wr_col   = CW'(c);
    lamp_wr_data  = d;
    lamp_commit   = commit;
    step();
    lamp_wr_valid = 1'b0;
    lamp_commit   = 1'b0;
  endtask

  task automatic pulse_commit();
    lamp_commit = 1'b1;
    step();
    lamp_commit = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge hwclk);
    #2 reset_n = 1'b1;
  endtask

  initial begin : stim
    repeat (3) @(posedge hwclk);
    release_reset();

    // Idle frames: timing of frame_start and first column drive.
    repeat (130) step();
    check("fs_hits_count", 32'(fs_hits.size() >= 2), 32'd1);
    check("fs_first", (fs_hits.size() > 0) ? 32'(fs_hits[0]) : 32'hFFFF, 32'd0);
    check("fs_second", (fs_hits.size() > 1) ? 32'(fs_hits[1]) : 32'hFFFF, 32'd100);
    check("col0_first_on", 32'(first_c0), 32'd4);

    // Write col 2, commit at frame cycle 10.
    goto(9);
    do_write(2, 8'hA5, 1'b0);
    pulse_commit();
    check("ready_after_commit", 32'(lamp_wr_ready), 32'd0);
    goto(99);
    check("ready_before_wrap", 32'(lamp_wr_ready), 32'd0);
    goto(0);
    check("ready_after_wrap", 32'(lamp_wr_ready), 32'd1);
    goto(50);
    check("col2_drive", 32'(col_drive_n), 32'h1B);
    check("col2_row", 32'(row_drive), 32'hA5);
    goto(70);
    check("col3_row", 32'(row_drive), 32'h00);

    // Write plus commit in one cycle, then a redundant commit.
    goto(30);
    do_write(1, 8'h3C, 1'b1);
    pulse_commit();
    check("pending_after_dup", 32'(commit_pending), 32'd1);
    goto(0);
    check("pending_cleared", 32'(commit_pending), 32'd0);
    goto(30);
    check("col1_drive", 32'(col_drive_n), 32'h1D);
    check("col1_row", 32'(row_drive), 32'h3C);

    // Out-of-range column: handshake completes, nothing changes.
    goto(5);
    check("ready_oor", 32'(lamp_wr_ready), 32'd1);
    do_write(7, 8'hFF, 1'b0);
    check("pending_oor", 32'(commit_pending), 32'd0);
    pulse_commit();
    goto(0);
    goto(10);
    check("oor_col0", 32'(row_drive), 32'h00);
    goto(30);
    check("oor_col1", 32'(row_drive), 32'h3C);
    goto(50);
    check("oor_col2", 32'(row_drive), 32'hA5);
    goto(70);
    check("oor_col3", 32'(row_drive), 32'h00);
    goto(90);
    check("oor_col4", 32'(row_drive), 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      lamp_wr_valid = ($urandom % 3) == 0;
      lamp_wr_col   = CW'($urandom % 8);
      lamp_wr_data  = ROWS'($urandom);
`ifdef LAMP_BLINK_EN
      blink_wr_data = ROWS'($urandom);
`endif
      lamp_commit   = ($urandom % 50) == 0;
      step();
    end
    lamp_wr_valid = 1'b0;
    lamp_commit   = 1'b0;

    // Asynchronous reset while column 2 is lit.
    goto(0);
    goto(1);
`ifdef LAMP_BLINK_EN
    blink_wr_data = '0;
`endif
    do_write(2, 8'h81, 1'b1);
    goto(0);
    goto(50);
    check("pre_reset_row", 32'(row_drive), 32'h81);
    #2 reset_n = 1'b0;
    #1;
    check("async_col_off", 32'(col_drive_n), 32'h1F);
    check("async_row_off", 32'(row_drive), 32'h00);
    check("async_fs_off", 32'(frame_start), 32'd0);
    check("async_ready", 32'(lamp_wr_ready), 32'd1);
    release_reset();
    goto(50);
    check("post_reset_front", 32'(row_drive), 32'h00);
    pulse_commit();
    goto(0);
    goto(50);
    check("post_reset_back_c2", 32'(row_drive), 32'h00);
    goto(30);
    check("post_reset_back_c1", 32'(row_drive), 32'h00);

`ifdef LAMP_BLINK_EN
    goto(1);
    blink_wr_data = 8'h0F;
    do_write(0, 8'hFF, 1'b1);
    blink_wr_data = '0;
    goto(0);
    for (int f = 0; f < 5; f++) begin
      goto(10);
      check("blink_row", 32'(row_drive), blink_phase ? 32'hF0 : 32'hFF);
    end
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
